// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO and sends each word as an asynchronous serial
// frame (start bit, DATA_WIDTH data bits LSB first, optional even parity bit,
// one stop bit). Consecutive words go out back to back with no idle gap.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   enable     1 allows new frames to start; a running frame always completes
//   empty      FIFO empty flag
//   fifo_data  FIFO head word, valid while empty=0
//   read       one-cycle pop strobe to the FIFO (combinational)
//   tx         serial output, idles high (registered)
//   busy       1 while a frame is in progress (registered)
//   tx_done    one-cycle pulse in the last cycle of each stop bit (registered)
//   dbg_state  current FSM state encoding (0 IDLE, 1 START, 2 DATA,
//              3 PARITY, 4 STOP)
//
// Handshake: the FIFO presents its head word on fifo_data while empty=0.
// read is asserted for exactly one cycle, only when empty=0, and the word on
// fifo_data in that cycle is captured on the following rising edge; the FIFO
// advances its head on that same edge.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  read,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic [2:0]            dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         baud_cnt, baud_next;
  logic [IW-1:0]         bit_idx, idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  parity, parity_next;
  logic                  tx_next, busy_next, done_next;
  logic                  baud_last;
  logic                  load;

  assign baud_last = (baud_cnt == BAUD_LAST);

  // A word is loaded either from IDLE or in the final cycle of STOP, which is
  // what makes back-to-back frames gapless. Gating with reset keeps the pop
  // strobe low while the block is held in reset.
  assign load = reset & enable & ~empty &
                ((state == IDLE) | ((state == STOP) & baud_last));

  assign read      = load;
  assign dbg_state = state;

  always_comb begin
    state_next  = state;
    baud_next   = baud_last ? '0 : baud_cnt + CW'(1);
    idx_next    = bit_idx;
    shift_next  = shift_reg;
    parity_next = parity;

    case (state)
      IDLE: begin
        baud_next = '0;
        if (load) state_next = START;
      end
      START: begin
        if (baud_last) state_next = DATA;
      end
      DATA: begin
        if (baud_last) begin
          shift_next = shift_reg >> 1;
          idx_next   = bit_idx + IW'(1);
          if (bit_idx == IDX_LAST) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (baud_last) state_next = STOP;
      end
      STOP: begin
        if (baud_last) state_next = load ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      shift_next  = fifo_data;
      parity_next = ^fifo_data;
      idx_next    = '0;
    end

    // The baud counter restarts on every state change.
    if (state_next != state) baud_next = '0;

    // Outputs are registered, so they are derived from the next-state values.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && (baud_next == BAUD_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= idx_next;
      shift_reg <= shift_next;
      parity    <= parity_next;
      tx        <= tx_next;
      busy      <= busy_next;
      tx_done   <= done_next;
    end
  end

endmodule
